// File: rtl/rgb_to_565_conv_if.sv
// Pixel bus between the sprite colour lookup and the RGB565 packer.
// The master drives the channel codes; the slave returns the packed word.
interface rgb_to_565_conv_if #(
  parameter int IN_W = 1
);
  logic [IN_W-1:0] iR;
  logic [IN_W-1:0] iG;
  logic [IN_W-1:0] iB;
  logic            iValid;
  logic [15:0]     oRGB_565;
  logic            oValid;

  modport master (
    output iR, iG, iB, iValid,
    input  oRGB_565, oValid
  );

  modport slave (
    input  iR, iG, iB, iValid,
    output oRGB_565, oValid
  );
endinterface

// File: rtl/rgb_to_565_conv.sv
// Scales IN_W-bit R/G/B codes to 5/6/5 bits and registers the packed RGB565 word.
// One cycle of latency; the colour register is free-running and does not hold on !iValid.
module rgb_to_565_conv #(
  parameter int IN_W      = 1,
  parameter int BGR_ORDER = 0
) (
  input  logic             iVGA_CLK,
  input  logic             iReset,
  rgb_to_565_conv_if.slave pix
);

  if ((IN_W < 1) || (IN_W > 8)) begin : g_bad_in_w
    $error("rgb_to_565_conv: IN_W must be within 1..8");
  end

  logic [4:0]  red_s;
  logic [5:0]  grn_s;
  logic [4:0]  blu_s;
  logic [15:0] packed_s;
  logic [15:0] rgb_r;
  logic        valid_r;

  // Output bit j (counted from the MSB) takes input bit (j mod IN_W) from the MSB:
  // this is truncation when IN_W >= target and MSB-first replication otherwise.
  for (genvar j = 0; j < 5; j++) begin : g_scale5
    assign red_s[4-j] = pix.iR[IN_W-1-(j % IN_W)];
    assign blu_s[4-j] = pix.iB[IN_W-1-(j % IN_W)];
  end

  for (genvar j = 0; j < 6; j++) begin : g_scale6
    assign grn_s[5-j] = pix.iG[IN_W-1-(j % IN_W)];
  end

  if (BGR_ORDER != 0) begin : g_bgr
    assign packed_s = {blu_s, grn_s, red_s};
  end else begin : g_rgb
    assign packed_s = {red_s, grn_s, blu_s};
  end

  // Single output stage: packed colour and its qualifier.
  always_ff @(posedge iVGA_CLK) begin
    if (iReset) begin
      rgb_r   <= 16'h0000;
      valid_r <= 1'b0;
    end else begin
      rgb_r   <= packed_s;
      valid_r <= pix.iValid;
    end
  end

  assign pix.oRGB_565 = rgb_r;
  assign pix.oValid   = valid_r;

endmodule

// File: tb/tb_rgb_to_565_conv.sv
// Self-checking bench for rgb_to_565_conv over several IN_W / BGR_ORDER configurations,
// compared against an arithmetic model of channel scaling and packing.
module tb_rgb_to_565_conv;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  logic [7:0] cur_r, cur_g, cur_b;
  logic       cur_v, cur_rst;

  rgb_to_565_conv_if #(.IN_W(1)) if_a ();
  rgb_to_565_conv_if #(.IN_W(1)) if_b ();
  rgb_to_565_conv_if #(.IN_W(3)) if_3 ();
  rgb_to_565_conv_if #(.IN_W(5)) if_5 ();
  rgb_to_565_conv_if #(.IN_W(8)) if_8 ();

  rgb_to_565_conv #(.IN_W(1), .BGR_ORDER(0)) u_a (.iVGA_CLK(clk), .iReset(rst), .pix(if_a.slave));
  rgb_to_565_conv #(.IN_W(1), .BGR_ORDER(1)) u_b (.iVGA_CLK(clk), .iReset(rst), .pix(if_b.slave));
  rgb_to_565_conv #(.IN_W(3), .BGR_ORDER(0)) u_3 (.iVGA_CLK(clk), .iReset(rst), .pix(if_3.slave));
  rgb_to_565_conv #(.IN_W(5), .BGR_ORDER(1)) u_5 (.iVGA_CLK(clk), .iReset(rst), .pix(if_5.slave));
  rgb_to_565_conv #(.IN_W(8), .BGR_ORDER(0)) u_8 (.iVGA_CLK(clk), .iReset(rst), .pix(if_8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Concatenate the code with itself until at least t bits exist, then keep the top t bits.
  function automatic logic [5:0] scale(input int w, input int t, input logic [7:0] v);
    int          mask;
    int          bits;
    logic [15:0] acc;
    logic [7:0]  mv;
    mask = (1 << w) - 1;
    mv   = v & mask[7:0];
    acc  = 16'h0000;
    bits = 0;
    while (bits < t) begin
      acc  = (acc << w) | {8'h00, mv};
      bits = bits + w;
    end
    acc = acc >> (bits - t);
    return acc[5:0];
  endfunction

  function automatic logic [15:0] model(input int w, input int bgr, input logic rs,
                                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    logic [5:0] r5, g6, b5;
    if (rs) return 16'h0000;
    r5 = scale(w, 5, r);
    g6 = scale(w, 6, g);
    b5 = scale(w, 5, b);
    if (bgr != 0) return {b5[4:0], g6, r5[4:0]};
    return {r5[4:0], g6, b5[4:0]};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic rs, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input logic v);
    rst = rs; cur_rst = rs;
    cur_r = r; cur_g = g; cur_b = b; cur_v = v;
    if_a.iR = r[0];   if_a.iG = g[0];   if_a.iB = b[0];   if_a.iValid = v;
    if_b.iR = r[0];   if_b.iG = g[0];   if_b.iB = b[0];   if_b.iValid = v;
    if_3.iR = r[2:0]; if_3.iG = g[2:0]; if_3.iB = b[2:0]; if_3.iValid = v;
    if_5.iR = r[4:0]; if_5.iG = g[4:0]; if_5.iB = b[4:0]; if_5.iValid = v;
    if_8.iR = r;      if_8.iG = g;      if_8.iB = b;      if_8.iValid = v;
  endtask

  // Clock the applied inputs through and check every instance against the model.
  task automatic tick();
    logic ev;
    @(posedge clk);
    #1;
    ev = cur_rst ? 1'b0 : cur_v;
    chk("w1_rgb", if_a.oRGB_565, model(1, 0, cur_rst, cur_r, cur_g, cur_b));
    chk("w1_bgr", if_b.oRGB_565, model(1, 1, cur_rst, cur_r, cur_g, cur_b));
    chk("w3_rgb", if_3.oRGB_565, model(3, 0, cur_rst, cur_r, cur_g, cur_b));
    chk("w5_bgr", if_5.oRGB_565, model(5, 1, cur_rst, cur_r, cur_g, cur_b));
    chk("w8_rgb", if_8.oRGB_565, model(8, 0, cur_rst, cur_r, cur_g, cur_b));
    chk("valid_a", {15'h0000, if_a.oValid}, {15'h0000, ev});
    chk("valid_8", {15'h0000, if_8.oValid}, {15'h0000, ev});
  endtask

  logic [15:0] sweep_exp [8];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    sweep_exp = '{16'h0000, 16'hF800, 16'h07E0, 16'h001F, 16'hFFE0, 16'h07FF, 16'hF81F, 16'hFFFF};

    // Reset held for three edges with all-ones colour and iValid=1.
    set_in(1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_rgb", if_a.oRGB_565, 16'h0000);
      chk("rst_valid", {15'h0000, if_a.oValid}, 16'h0000);
    end
    set_in(1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    tick();
    chk("rel_rgb", if_a.oRGB_565, 16'hFFFF);
    chk("rel_valid", {15'h0000, if_a.oValid}, 16'h0001);

    // IN_W=1 sweep in the order 000,100,010,001,110,011,101,111 as {R,G,B}.
    begin
      logic [2:0] combo [8];
      combo = '{3'b000, 3'b100, 3'b010, 3'b001, 3'b110, 3'b011, 3'b101, 3'b111};
      for (int i = 0; i < 8; i++) begin
        logic [2:0] c;
        c = combo[i];
        set_in(1'b0, {7'h00, c[2]}, {7'h00, c[1]}, {7'h00, c[0]}, 1'b1);
        tick();
        chk("sweep", if_a.oRGB_565, sweep_exp[i]);
      end
    end

    set_in(1'b0, 8'h05, 8'h05, 8'h03, 1'b1);
    tick();
    chk("w3_replicate", if_3.oRGB_565, 16'hB5AD);

    set_in(1'b0, 8'hFF, 8'h80, 8'h0F, 1'b1);
    tick();
    chk("w8_truncate", if_8.oRGB_565, 16'hFC01);

    set_in(1'b0, 8'h01, 8'h00, 8'h00, 1'b1);
    tick();
    chk("bgr_red", if_b.oRGB_565, 16'h001F);
    set_in(1'b0, 8'h00, 8'h00, 8'h01, 1'b1);
    tick();
    chk("bgr_blue", if_b.oRGB_565, 16'hF800);

    // iValid 1,0,1 with changing colours; colour still updates while iValid=0.
    set_in(1'b0, 8'h01, 8'h00, 8'h00, 1'b1);
    tick();
    chk("vt_rgb0", if_a.oRGB_565, 16'hF800);
    set_in(1'b0, 8'h00, 8'h01, 8'h00, 1'b0);
    tick();
    chk("vt_rgb1", if_a.oRGB_565, 16'h07E0);
    chk("vt_valid1", {15'h0000, if_a.oValid}, 16'h0000);
    set_in(1'b0, 8'h00, 8'h00, 8'h01, 1'b1);
    tick();
    chk("vt_rgb2", if_a.oRGB_565, 16'h001F);
    chk("vt_valid2", {15'h0000, if_a.oValid}, 16'h0001);
    set_in(1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    tick();
    chk("mid_rst", if_a.oRGB_565, 16'h0000);
    set_in(1'b0, 8'h01, 8'h01, 8'h00, 1'b1);
    tick();
    chk("post_rst", if_a.oRGB_565, 16'hFFE0);

    // Random pixels with occasional resets.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] rv;
      rv = $urandom;
      set_in(($urandom_range(0, 15) == 0), rv[7:0], rv[15:8], rv[23:16], rv[24]);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
